// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - ECP5 PLL reset/lock sequencer with timeout, stability window and bounded retries.
// Optional PLL standby support is compiled in with `define PLL_SEQ_STDBY_EN.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       clki,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       retrain_req,
`ifdef PLL_SEQ_STDBY_EN
  input  logic       stdby_req,
  output logic       pll_stdby,
`endif
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int CNT_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX = (CNT_AB > STABLE_CYCLES) ? CNT_AB : STABLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
`ifdef PLL_SEQ_STDBY_EN
    S_STANDBY,
`endif
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          lock_meta_q, lock_s_q;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;
  logic          fail;
`ifdef PLL_SEQ_STDBY_EN
  logic          pll_stdby_q, pll_stdby_d;
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;
    case (state_q)
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) state_d = S_SETTLE;
        else if (cnt_q == TIMEOUT_LAST) fail = 1'b1;
      end
      S_SETTLE: begin
        if (!lock_s_q) begin
          fail = 1'b1;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          retry_d = 4'd0;
        end
      end
      S_RUN: begin
`ifdef PLL_SEQ_STDBY_EN
        if (stdby_req) state_d = S_STANDBY;
        else if (!lock_s_q) fail = 1'b1;
`else
        if (!lock_s_q) fail = 1'b1;
`endif
      end
`ifdef PLL_SEQ_STDBY_EN
      S_STANDBY: begin
        if (!stdby_req) state_d = S_WAIT_LOCK;
      end
`endif
      S_FAULT: ;
      default: state_d = S_RESET;
    endcase

    if (fail) begin
      if (retry_q == RETRY_LIMIT) begin
        state_d = S_FAULT;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = S_RESET;
      end
    end

    // A retrain overrides any same-cycle failure and is never counted as one.
    if (retrain_req) begin
      state_d = S_RESET;
      retry_d = 4'd0;
    end

    if (state_d != state_q || retrain_req) cnt_d = '0;
    else if (state_q == S_RESET || state_q == S_WAIT_LOCK || state_q == S_SETTLE)
      cnt_d = cnt_q + CW'(1);
    else cnt_d = cnt_q;

    // Outputs are decoded from the next state so they change on the transition edge.
    pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAULT);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
`ifdef PLL_SEQ_STDBY_EN
    pll_stdby_d = (state_d == S_STANDBY);
`endif
  end

  always_ff @(posedge clki or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
`ifdef PLL_SEQ_STDBY_EN
      pll_stdby_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_meta_q <= pll_locked;
      lock_s_q    <= lock_meta_q;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
`ifdef PLL_SEQ_STDBY_EN
      pll_stdby_q <= pll_stdby_d;
`endif
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
`ifdef PLL_SEQ_STDBY_EN
  assign pll_stdby = pll_stdby_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - scoreboard bench for pll_lock_sequencer with default parameters.
module tb_pll_lock_sequencer;

  logic       clki;
  logic       rst_n;
  logic       pll_locked;
  logic       retrain_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;

  pll_lock_sequencer dut (
    .clki        (clki),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .retrain_req (retrain_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    string      name;
  } exp_t;

  exp_t q[$];
  int   edge_n = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t mon_e;
  logic [7:0] got;

  always @(posedge clki) edge_n++;

  // Expectations are tagged with the edge count after which they hold; sampled on the falling edge.
  always @(negedge clki) begin
    while (q.size() > 0 && q[0].cyc <= edge_n) begin
      mon_e = q.pop_front();
      got = {pll_rst, sys_rst_n, ready, fault, retry_cnt};
      checks++;
      if (mon_e.cyc != edge_n || got !== mon_e.v) begin
        failures++;
        $display("FAIL %s at edge %0d: got pll_rst/sys_rst_n/ready/fault/retry=%b_%b_%b_%b_%0d required %b_%b_%b_%b_%0d",
                 mon_e.name, edge_n, got[7], got[6], got[5], got[4], got[3:0],
                 mon_e.v[7], mon_e.v[6], mon_e.v[5], mon_e.v[4], mon_e.v[3:0]);
      end
    end
  end

  task automatic expect_at(input int k, input logic pr, input logic srn, input logic rdy,
                           input logic flt, input logic [3:0] rc, input string nm);
    exp_t e;
    e.cyc  = base + k;
    e.v    = {pr, srn, rdy, flt, rc};
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic wait_to(input int k);
    while (edge_n < base + k) @(negedge clki);
  endtask

  task automatic release_reset();
    @(posedge clki);
    #2 rst_n = 1'b1;
    base = edge_n;
  endtask

  task automatic hold_reset(input logic lock);
    @(negedge clki);
    rst_n = 1'b0;
    pll_locked = lock;
    repeat (3) @(negedge clki);
  endtask

  int f;

  initial begin
    rst_n = 1'b0;
    pll_locked = 1'b0;
    retrain_req = 1'b0;
    repeat (3) @(negedge clki);

    // Lock rises 40 clocks after release: RUN after 42+256+1 clocks.
    release_reset();
    expect_at(0,   1, 0, 0, 0, 0, "reset_values");
    expect_at(15,  1, 0, 0, 0, 0, "pll_rst_held");
    expect_at(16,  0, 0, 0, 0, 0, "pll_rst_falls");
    expect_at(298, 0, 0, 0, 0, 0, "settle_last");
    expect_at(299, 0, 1, 1, 0, 0, "run_entry");
    wait_to(40);
    pll_locked = 1'b1;

    // One-clock lock drop in RUN: reset 3 edges later, full re-run.
    expect_at(312, 0, 1, 1, 0, 0, "run_before_loss");
    expect_at(313, 1, 0, 0, 0, 1, "loss_to_reset");
    expect_at(328, 1, 0, 0, 0, 1, "rerun_reset");
    expect_at(329, 0, 0, 0, 0, 1, "rerun_wait");
    expect_at(585, 0, 0, 0, 0, 1, "rerun_settle");
    expect_at(586, 0, 1, 1, 0, 0, "rerun_run_clear");
    wait_to(310);
    pll_locked = 1'b0;
    wait_to(311);
    pll_locked = 1'b1;

    // Retrain and lock loss on the same edge, then lock stays low.
    expect_at(602, 0, 1, 1, 0, 0, "run_before_retrain");
    expect_at(603, 1, 0, 0, 0, 0, "retrain_wins");
    for (int n = 1; n <= 4; n++) begin
      f = 603 + n * 4112;
      expect_at(f - 1, 0, 0, 0, 0, 4'(n - 1), "timeout_edge_minus1");
      if (n < 4) expect_at(f, 1, 0, 0, 0, 4'(n), "timeout_retry");
      else       expect_at(f, 1, 0, 0, 1, 4'd3, "fault_entry");
    end
    f = 603 + 4 * 4112;
    expect_at(f + 50,  1, 0, 0, 1, 3, "fault_sticky");
    expect_at(f + 100, 1, 0, 0, 1, 3, "fault_before_retrain");
    expect_at(f + 101, 1, 0, 0, 0, 0, "fault_retrain_reset");
    wait_to(600);
    pll_locked = 1'b0;
    wait_to(602);
    retrain_req = 1'b1;
    wait_to(603);
    retrain_req = 1'b0;
    wait_to(f + 100);
    retrain_req = 1'b1;
    wait_to(f + 101);
    retrain_req = 1'b0;
    wait_to(f + 102);

    // Lock already high; drop it so SETTLE sees loss at cnt=100.
    hold_reset(1'b1);
    release_reset();
    expect_at(0,   1, 0, 0, 0, 0, "reset_values_2");
    expect_at(117, 0, 0, 0, 0, 0, "settle_cnt100");
    expect_at(118, 1, 0, 0, 0, 1, "settle_loss_reset");
    expect_at(200, 0, 0, 0, 0, 1, "no_run_200");
    expect_at(273, 0, 0, 0, 0, 1, "no_run_273");
    expect_at(274, 0, 0, 0, 0, 1, "no_run_274");
    expect_at(400, 0, 0, 0, 0, 1, "no_run_400");
    expect_at(411, 1, 0, 0, 0, 0, "async_reset");
    expect_at(412, 1, 0, 0, 0, 0, "reset_held");
    wait_to(115);
    pll_locked = 1'b0;

    // Asynchronous reset between edges while in WAIT_LOCK.
    wait_to(410);
    @(posedge clki);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, sys_rst_n, ready, fault, retry_cnt} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL async_reset_immediate: got pll_rst/sys_rst_n/ready/fault/retry=%b_%b_%b_%b_%0d",
               pll_rst, sys_rst_n, ready, fault, retry_cnt);
    end
    checks++;
    if (retry_cnt !== 4'd0) begin
      failures++;
      $display("FAIL async_reset_retry_clear: got retry=%0d", retry_cnt);
    end
    wait_to(414);

    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: never sampled, required edge %0d", mon_e.name, mon_e.cyc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
